bcd_counter_3dig: RTL and testbench

Three-digit BCD up/down counter, feeding the `digits[11:0]` input of the `display_7_seg` multiplexer on the Nexys4 DDR counter design. It divides CLK down to a count rate and steps a packed three-digit BCD value. The value can be cleared, loaded or single-stepped. Every output is registered, so the display stage samples a stable, glitch-free value.

---
 rtl/bcd_counter_3dig_pkg.sv | 16 +
 rtl/bcd_counter_3dig_digit.sv | 48 ++++
 rtl/bcd_counter_3dig.sv | 108 ++++++++++
 tb/tb_bcd_counter_3dig.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_3dig_pkg.sv
// Shared constants and helpers for the three-digit BCD counter.
package bcd_counter_3dig_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned DIGITS_W   = BCD_W * NUM_DIGITS;
    localparam int unsigned PRESC_W    = 26;

    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    // Clamp a raw nibble into the legal BCD range so the count never holds A..F.
    function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

endpackage

// File: rtl/bcd_counter_3dig_digit.sv
// One BCD digit: registered value with combinational carry/borrow-out for chaining.
module bcd_digit
    import bcd_counter_3dig_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             step_i,
    input  logic             up_i,
    input  logic             cin_i,
    input  logic             load_i,
    input  logic [BCD_W-1:0] load_nib_i,
    input  logic             clr_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             cout_c_o
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;
    logic             at_limit_c;

    always_comb begin
        at_limit_c = up_i ? (digit_q == BCD_MAX) : (digit_q == '0);
        cout_c_o   = cin_i & at_limit_c;
        digit_d    = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (load_i) begin
            digit_d = bcd_sat(load_nib_i);
        end else if (step_i && cin_i) begin
            if (at_limit_c) begin
                digit_d = up_i ? BCD_W'(0) : BCD_MAX;
            end else begin
                digit_d = up_i ? (digit_q + BCD_W'(1)) : (digit_q - BCD_W'(1));
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/bcd_counter_3dig.sv
// Three-digit BCD up/down counter with prescaler, manual step input and clear/load.
module bcd_counter_3dig
    import bcd_counter_3dig_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                EN,
    input  logic                UP,
    input  logic                CLR,
    input  logic                LOAD,
    input  logic [DIGITS_W-1:0] LOAD_VAL,
    input  logic                STEP,
    output logic [DIGITS_W-1:0] digits,
    output logic                TICK,
    output logic                WRAP
);

    localparam logic [PRESC_W-1:0] TERM_CNT = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               sync1_q, sync2_q, step_prev_q;
    logic               tick_q, tick_d;
    logic               wrap_q, wrap_d;

    logic               tick_c, man_step_c, hold_c, step_c;
    logic               cout_u_c, cout_t_c, cout_h_c;
    logic [BCD_W-1:0]   dig_u, dig_t, dig_h;

    // Clear/load override any tick or manual step in the same cycle.
    always_comb begin
        tick_c     = EN && (presc_q == TERM_CNT);
        man_step_c = sync2_q & ~step_prev_q;
        hold_c     = CLR | LOAD;
        step_c     = (tick_c | man_step_c) & ~hold_c;
        presc_d    = presc_q;
        if (hold_c || tick_c) begin
            presc_d = '0;
        end else if (EN) begin
            presc_d = presc_q + PRESC_W'(1);
        end
        tick_d = tick_c & ~hold_c;
        wrap_d = step_c & cout_h_c;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_q     <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            step_prev_q <= 1'b0;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            sync1_q     <= STEP;
            sync2_q     <= sync1_q;
            step_prev_q <= sync2_q;
            tick_q      <= tick_d;
            wrap_q      <= wrap_d;
        end
    end

    bcd_digit u_units (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .step_i     (step_c),
        .up_i       (UP),
        .cin_i      (1'b1),
        .load_i     (LOAD),
        .load_nib_i (LOAD_VAL[3:0]),
        .clr_i      (CLR),
        .digit_o    (dig_u),
        .cout_c_o   (cout_u_c)
    );

    bcd_digit u_tens (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .step_i     (step_c),
        .up_i       (UP),
        .cin_i      (cout_u_c),
        .load_i     (LOAD),
        .load_nib_i (LOAD_VAL[7:4]),
        .clr_i      (CLR),
        .digit_o    (dig_t),
        .cout_c_o   (cout_t_c)
    );

    bcd_digit u_hundreds (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .step_i     (step_c),
        .up_i       (UP),
        .cin_i      (cout_t_c),
        .load_i     (LOAD),
        .load_nib_i (LOAD_VAL[11:8]),
        .clr_i      (CLR),
        .digit_o    (dig_h),
        .cout_c_o   (cout_h_c)
    );

    assign digits = {dig_h, dig_t, dig_u};
    assign TICK   = tick_q;
    assign WRAP   = wrap_q;

endmodule

// File: tb/tb_bcd_counter_3dig.sv
// Randomized self-checking bench for bcd_counter_3dig against an integer-valued reference model.
module tb_bcd_counter_3dig;

    localparam int TD = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        EN, UP, CLR, LOAD, STEP;
    logic [11:0] LOAD_VAL;
    logic [11:0] digits;
    logic        TICK, WRAP;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: count as a plain integer 0..999, STEP as a sample history.
    int m_val;
    int m_presc;
    bit m_tick, m_wrap;
    bit hist [3];

    bcd_counter_3dig #(.TICK_DIV(TD)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .EN       (EN),
        .UP       (UP),
        .CLR      (CLR),
        .LOAD     (LOAD),
        .LOAD_VAL (LOAD_VAL),
        .STEP     (STEP),
        .digits   (digits),
        .TICK     (TICK),
        .WRAP     (WRAP)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %03h expected %03h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int sat_val(input logic [11:0] lv);
        int h, t, u;
        h = (lv[11:8] > 4'd9) ? 9 : int'(lv[11:8]);
        t = (lv[7:4]  > 4'd9) ? 9 : int'(lv[7:4]);
        u = (lv[3:0]  > 4'd9) ? 9 : int'(lv[3:0]);
        return h * 100 + t * 10 + u;
    endfunction

    function automatic bit bcd_valid(input logic [11:0] d);
        return (d[11:8] <= 4'd9) && (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
    endfunction

    task automatic model_reset();
        m_val   = 0;
        m_presc = 0;
        m_tick  = 1'b0;
        m_wrap  = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = 1'b0;
    endtask

    // Manual step fires on the edge two edges after STEP is first sampled high.
    task automatic model_edge();
        bit tk, man;
        tk = EN && (m_presc == TD - 1);
        man = hist[1] && !hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = STEP;
        m_tick = 1'b0;
        m_wrap = 1'b0;
        if (CLR) begin
            m_val = 0;
            m_presc = 0;
        end else if (LOAD) begin
            m_val = sat_val(LOAD_VAL);
            m_presc = 0;
        end else begin
            if (EN) m_presc = tk ? 0 : m_presc + 1;
            m_tick = tk;
            if (tk || man) begin
                if (UP) begin
                    m_wrap = (m_val == 999);
                    m_val = (m_val + 1) % 1000;
                end else begin
                    m_wrap = (m_val == 0);
                    m_val = (m_val + 999) % 1000;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        chk("digits", digits, to_bcd(m_val));
        chk("tick", {11'b0, TICK}, {11'b0, m_tick});
        chk("wrap", {11'b0, WRAP}, {11'b0, m_wrap});
        chk("bcd_ok", {11'b0, bcd_valid(digits)}, 12'd1);
    endtask

    // Called at a falling edge; asserts reset between clock edges and checks it acts at once.
    task automatic do_reset();
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        chk("async_rst_digits", digits, 12'h000);
        chk("async_rst_tick", {11'b0, TICK}, 12'd0);
        chk("async_rst_wrap", {11'b0, WRAP}, 12'd0);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0; EN = 1'b0; UP = 1'b1; CLR = 1'b0; LOAD = 1'b0;
        STEP = 1'b0; LOAD_VAL = 12'h000;
        model_reset();
        repeat (2) @(negedge CLK);
        chk("reset_digits", digits, 12'h000);
        chk("reset_tick", {11'b0, TICK}, 12'd0);
        chk("reset_wrap", {11'b0, WRAP}, 12'd0);

        RST_N = 1'b1; EN = 1'b1; UP = 1'b1;
        repeat (40) cycle();
        chk("run40", digits, 12'h010);

        LOAD = 1'b1; LOAD_VAL = 12'h998;
        cycle();
        LOAD = 1'b0;
        repeat (4) cycle();
        chk("up_to_999", digits, 12'h999);
        repeat (4) cycle();
        chk("up_wrap_digits", digits, 12'h000);
        chk("up_wrap_flag", {11'b0, WRAP}, 12'd1);
        chk("up_wrap_tick", {11'b0, TICK}, 12'd1);

        UP = 1'b0;
        repeat (4) cycle();
        chk("down_wrap_digits", digits, 12'h999);
        chk("down_wrap_flag", {11'b0, WRAP}, 12'd1);
        LOAD = 1'b1; LOAD_VAL = 12'h100;
        cycle();
        LOAD = 1'b0;
        repeat (4) cycle();
        chk("down_borrow", digits, 12'h099);

        UP = 1'b1; LOAD = 1'b1; LOAD_VAL = 12'hFAB;
        cycle();
        LOAD = 1'b0;
        chk("load_sat", digits, 12'h999);

        repeat (3) cycle();
        CLR = 1'b1; LOAD = 1'b1; LOAD_VAL = 12'h555;
        cycle();
        chk("clr_wins_digits", digits, 12'h000);
        chk("clr_wins_wrap", {11'b0, WRAP}, 12'd0);
        CLR = 1'b0; LOAD = 1'b0;
        repeat (4) cycle();
        chk("presc_restart", digits, 12'h001);

        EN = 1'b0; STEP = 1'b1;
        cycle();
        cycle();
        chk("step_latency_2", digits, 12'h001);
        cycle();
        chk("step_latency_3", digits, 12'h002);
        STEP = 1'b0;
        repeat (4) cycle();
        chk("step_single", digits, 12'h002);

        EN = 1'b1;
        cycle();
        STEP = 1'b1;
        repeat (3) cycle();
        STEP = 1'b0;
        chk("step_tick_merge", digits, 12'h003);
        repeat (6) cycle();
        do_reset();

        for (int i = 0; i < 1500; i++) begin
            EN       = ($urandom_range(3) != 0);
            UP       = $urandom_range(1) != 0;
            CLR      = ($urandom_range(31) == 0);
            LOAD     = ($urandom_range(15) == 0);
            LOAD_VAL = 12'($urandom());
            if ($urandom_range(3) == 0) STEP = ~STEP;
            if (i % 400 == 399) do_reset();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
